// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: hands a nonce range out to a hashing core one nonce per
// accepted handshake, then collects winning nonces into a small FIFO and
// releases them as rate-limited golden_nonce pulses.
// Optional feature macro: NONCE_STATS_EN adds the hashes_done counter output.
module nonce_dispatcher #(
  parameter int unsigned PIPE_LAT   = 65,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        hash_clk,
  input  logic        reset,
  input  logic        new_work,
  input  logic [31:0] nonce_min,
  input  logic [31:0] nonce_max,
  input  logic        core_ready,
  output logic [31:0] nonce_out,
  output logic        nonce_valid,
  input  logic        hash_valid,
  input  logic        hash_hit,
  input  logic [31:0] hash_nonce,
  output logic [31:0] golden_nonce,
  output logic        new_golden_nonce,
  output logic        busy,
  output logic        job_done,
  output logic        fifo_overflow
`ifdef NONCE_STATS_EN
  ,
  output logic [31:0] hashes_done
`endif
);

  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned FW = $clog2(PIPE_LAT + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   max_r;
  logic [DW-1:0] drain_cnt;

  logic [FW-1:0] flush_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] fifo_cnt;

  logic hit_ok;
  logic fifo_full;
  logic pop;
  logic push;

  // Job FSM: nonce_out doubles as the issue counter, so it holds while core_ready=0
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      nonce_out   <= '0;
      nonce_valid <= 1'b0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      max_r       <= '0;
      drain_cnt   <= '0;
    end else if (new_work) begin
      nonce_out <= nonce_min;
      max_r     <= nonce_max;
      drain_cnt <= '0;
      if (nonce_min <= nonce_max) begin
        state       <= S_RUN;
        nonce_valid <= 1'b1;
        busy        <= 1'b1;
        job_done    <= 1'b0;
      end else begin
        state       <= S_DONE;
        nonce_valid <= 1'b0;
        busy        <= 1'b0;
        job_done    <= 1'b1;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (core_ready) begin
            // Stop on the last nonce instead of incrementing, so FFFFFFFF never wraps to 0
            if (nonce_out == max_r) begin
              state       <= S_DRAIN;
              nonce_valid <= 1'b0;
            end else begin
              nonce_out <= nonce_out + 32'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(PIPE_LAT - 1)) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            job_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Hit qualification and FIFO push/pop decisions
  always_comb begin
    hit_ok    = hash_valid & hash_hit & ~new_work & (flush_cnt == '0);
    fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
    pop       = (fifo_cnt != '0) & (gap_cnt == '0);
    push      = hit_ok & (~fifo_full | pop);
  end

  // Flush window, FIFO pointers, pulse pacing and sticky overflow
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      flush_cnt        <= '0;
      gap_cnt          <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      fifo_cnt         <= '0;
      golden_nonce     <= '0;
      new_golden_nonce <= 1'b0;
      fifo_overflow    <= 1'b0;
    end else begin
      // Results still in flight from the previous job surface for PIPE_LAT cycles
      if (new_work) begin
        flush_cnt <= FW'(PIPE_LAT);
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end

      new_golden_nonce <= pop;
      if (pop) begin
        golden_nonce <= mem[rd_ptr];
        rd_ptr       <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        gap_cnt      <= GW'(GAP_CYCLES);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      if (push) begin
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase

      if (hit_ok & fifo_full & ~pop) begin
        fifo_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge hash_clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= hash_nonce;
    end
  end

`ifdef NONCE_STATS_EN
  // Saturating count of accepted handshakes for the current job
  always_ff @(posedge hash_clk) begin
    if (reset || new_work) begin
      hashes_done <= '0;
    end else if (nonce_valid && core_ready && (hashes_done != '1)) begin
      hashes_done <= hashes_done + 32'd1;
    end
  end
`endif

endmodule
